sram_controller: RTL

- MEM-stage initiator for the data path: takes the pipeline's 32-bit read/write request and performs it on an external 16-bit asynchronous SRAM in two half-word phases.
- Drops `ready` while busy; the pipeline freezes its stages on `!ready`.
- Uses the same address map as the on-chip data memory: byte address minus BASE_ADDR, divided by 4.
- Sits between the EXE/MEM register and the MEM/WB register.

---
 rtl/sram_controller_pkg.sv | 14 +
 rtl/sram_controller_if.sv | 23 ++
 rtl/sram_controller.sv | 98 +++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the two-phase 16-bit SRAM controller.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int CNT_W  = 3;
  localparam int SRAM_W = 16;

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle between the MEM stage and the SRAM controller.
interface sram_controller_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  mem_read_in;
  logic                  mem_write_in;
  logic [DATA_WIDTH-1:0] address_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  ready;

  modport master (
    output mem_read_in, mem_write_in, address_in, data_in,
    input  read_data, ready
  );

  modport slave (
    input  mem_read_in, mem_write_in, address_in, data_in,
    output read_data, ready
  );

endinterface

// File: rtl/sram_controller.sv
// Performs one 32-bit pipeline load/store as two half-word accesses on an
// external asynchronous 16-bit SRAM, holding ready low until the access completes.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int          DATA_WIDTH      = 32,
  parameter int unsigned BASE_ADDR       = 1024,
  parameter int          SRAM_ADDR_WIDTH = 18,
  parameter int          WAIT_CYCLES     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  sram_controller_if.slave           bus,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [SRAM_W-1:0]          sram_dq,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);

  localparam int IDX_W = SRAM_ADDR_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] BASE = DATA_WIDTH'(BASE_ADDR);

  // Byte address to word index; addresses outside the SRAM wrap silently.
  function automatic logic [IDX_W-1:0] word_index(input logic [DATA_WIDTH-1:0] byte_addr);
    return IDX_W'((byte_addr - BASE) >> 2);
  endfunction

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  op_write;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [DATA_WIDTH-1:0] read_reg;

  logic              req;
  logic              in_phase;
  logic              hi_phase;
  logic              phase_last;
  logic              dq_en;
  logic [SRAM_W-1:0] dq_out;

  assign req        = bus.mem_read_in | bus.mem_write_in;
  assign in_phase   = (state == ST_LOW) || (state == ST_HIGH);
  assign hi_phase   = (state == ST_HIGH);
  assign phase_last = (cnt == CNT_W'(WAIT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      data_reg <= '0;
      idx_reg  <= '0;
      read_reg <= '0;
    end else begin
      state <= state_nxt;
      if (in_phase && !phase_last) cnt <= cnt + 1'b1;
      else                         cnt <= '0;
      // Write wins when both request lines are up.
      if (state == ST_IDLE && req) begin
        op_write <= bus.mem_write_in;
        data_reg <= bus.data_in;
        idx_reg  <= word_index(bus.address_in);
      end
      if (in_phase && phase_last && !op_write) begin
        if (hi_phase) read_reg[DATA_WIDTH-1:SRAM_W] <= sram_dq;
        else          read_reg[SRAM_W-1:0]          <= sram_dq;
      end
    end
  end

  // DONE ignores the request lines: they still belong to the finishing instruction.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req)        state_nxt = ST_LOW;
      ST_LOW:  if (phase_last) state_nxt = ST_HIGH;
      ST_HIGH: if (phase_last) state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Write enable rises on the last cycle of a phase so address and data are
  // stable around the rising edge; with no wait cycles it spans the whole phase.
  always_comb begin
    bus.ready     = ((state == ST_IDLE) && !req) || (state == ST_DONE);
    bus.read_data = ((state == ST_DONE) && !op_write) ? read_reg : '0;
    sram_addr     = in_phase ? {idx_reg, hi_phase} : '0;
    sram_we_n     = !(in_phase && op_write && (!phase_last || (WAIT_CYCLES == 0)));
    sram_oe_n     = !(in_phase && !op_write);
    dq_en         = in_phase && op_write;
    dq_out        = hi_phase ? data_reg[DATA_WIDTH-1:SRAM_W] : data_reg[SRAM_W-1:0];
  end

  assign sram_dq = dq_en ? dq_out : {SRAM_W{1'bz}};

endmodule
